// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point accumulation controller:
// IEEE-754 single-precision field layout, the zero constant and the
// controller state encoding.
package fp_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIGN_BIT = 31;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  // IDLE waits for start, FIRST loads sample 0 directly, ACC folds the
  // remaining samples through the adder, DONE presents the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

endpackage : fp_pkg

// File: rtl/fp_accum_ctrl.sv
// Streams N single-precision samples through an external combinational
// FP add/sub stage and accumulates the running sum. Sample 0 bypasses the
// adder, so the accumulator never needs to start from zero. In subtract
// mode every sample after the first has its sign flipped before the add.
module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             sub_mode,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  input  logic [FP_W-1:0]  add_s,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_data,
  input  logic             out_ready,
  output logic             busy
);

  acc_state_e       state_q;
  logic [FP_W-1:0]  acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q;
  logic             inHandshake;
  logic             lastSample;

  // Status flags are pure decodes of the registered state, so in_ready
  // never depends on in_valid.
  always_comb begin
    in_ready    = (state_q == FIRST) || (state_q == ACC);
    out_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    out_data    = acc_q;
    add_a       = acc_q;
    add_b       = {in_data[SIGN_BIT] ^ sub_q, in_data[EXP_W+MAN_W-1:0]};
    inHandshake = in_valid && in_ready;
    lastSample  = (cnt_q == CNT_W'(1));
  end

  // Controller FSM together with the accumulator, sample counter and the
  // latched subtract flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= len;
            sub_q <= sub_mode;
            if (len == '0) begin
              acc_q   <= FP_ZERO;
              state_q <= DONE;
            end else begin
              state_q <= FIRST;
            end
          end
        end
        FIRST: begin
          if (inHandshake) begin
            acc_q   <= in_data;
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= lastSample ? DONE : ACC;
          end
        end
        ACC: begin
          if (inHandshake) begin
            acc_q   <= add_s;
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= lastSample ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : fp_accum_ctrl

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl. Provides a behavioural FP adder
// on add_a/add_b/add_s, runs a table of directed jobs, hand-written corner
// sequences and randomized jobs scored against a real-arithmetic model.
module tb_fp_accum_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             sub_mode;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_s;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] samples [0:15];

  typedef struct {
    string       name;
    int          n;
    bit          sub;
    logic [31:0] d [0:3];
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [0:5];

  fp_accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .sub_mode (sub_mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_s    (add_s),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision bits to real (normals and zero only).
  function automatic real singleToReal(input logic [31:0] s);
    logic [63:0] b;
    int          e;
    if (s[30:23] == 8'd0) return 0.0;
    e = int'(s[30:23]) - 127 + 1023;
    b = {s[31], e[10:0], s[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Real to single-precision bits, truncating the mantissa.
  function automatic logic [31:0] realToSingle(input real r);
    logic [63:0] b;
    int          e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Small signed integer to exact single-precision bits.
  function automatic logic [31:0] intToSingle(input int v);
    int          mag;
    int          p;
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    e = 127 + p;
    m = 32'(mag) << (23 - p);
    return {(v < 0), e[7:0], m[22:0]};
  endfunction

  // Behavioural combinational adder standing in for the real FP stage.
  always_comb add_s = realToSingle(singleToReal(add_a) + singleToReal(add_b));

  // Expected result: sample 0 as-is, then add or subtract every later
  // sample in ordinary real arithmetic.
  function automatic logic [31:0] refModel(input int n, input bit sub);
    real r;
    if (n == 0) return 32'h0;
    if (n == 1) return samples[0];
    r = singleToReal(samples[0]);
    for (int i = 1; i < n; i++)
      r = sub ? r - singleToReal(samples[i]) : r + singleToReal(samples[i]);
    return realToSingle(r);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete job: start, feed n samples (optionally with valid gaps and
  // ignored start pulses), hold the result for holdCycles, then release.
  task automatic applyStimulus(input string name, input int n, input bit sub,
                               input bit gaps, input int holdCycles,
                               input logic [31:0] expected);
    int  k;
    int  budget;
    bit  hs;
    start    = 1'b1;
    len      = CNT_W'(n);
    sub_mode = sub;
    step();
    start    = 1'b0;
    len      = CNT_W'(7);
    sub_mode = ~sub;
    checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
    k = 0;
    budget = 0;
    while (k < n && budget < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? samples[k] : 32'hDEAD_BEEF;
      start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      checkOutput({name, " in_ready while collecting"}, 32'(in_ready), 32'd1);
      hs = in_valid && in_ready;
      step();
      if (hs) k++;
      budget++;
    end
    start = 1'b0;
    if (k < n) checkOutput({name, " sample budget"}, 32'(k), 32'(n));
    checkOutput({name, " out_valid latency"}, 32'(out_valid), 32'd1);
    checkOutput({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    checkOutput({name, " out_data"}, out_data, expected);
    out_ready = 1'b0;
    for (int h = 0; h < holdCycles; h++) begin
      in_valid = 1'b1;
      in_data  = 32'h4120_0000;
      start    = gaps;
      step();
      checkOutput({name, " out_valid held"}, 32'(out_valid), 32'd1);
      checkOutput({name, " out_data held"}, out_data, expected);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({name, " out_valid after accept"}, 32'(out_valid), 32'd0);
    checkOutput({name, " busy after accept"}, 32'(busy), 32'd0);
  endtask

  task automatic setVec(input int idx, input string name, input int n,
                        input bit sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic [31:0] expected);
    vecs[idx].name     = name;
    vecs[idx].n        = n;
    vecs[idx].sub      = sub;
    vecs[idx].d[0]     = a;
    vecs[idx].d[1]     = b;
    vecs[idx].d[2]     = c;
    vecs[idx].d[3]     = d;
    vecs[idx].expected = expected;
  endtask

  // Hard stop in case the run wedges somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit sub;
    setVec(0, "sum3",     3, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0, 32'h40C0_0000);
    setVec(1, "sub2",     2, 1'b1, 32'h40A0_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h4040_0000);
    setVec(2, "len0",     0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000);
    setVec(3, "len1sub",  1, 1'b1, 32'hC049_0FDB, 32'h0, 32'h0, 32'h0, 32'hC049_0FDB);
    setVec(4, "sum4",     4, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4120_0000);
    setVec(5, "sub3",     3, 1'b1, 32'h4120_0000, 32'h4000_0000, 32'h4040_0000, 32'h0, 32'h40A0_0000);

    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    sub_mode  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    step();
    step();
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_data", out_data, 32'h0);
    rst = 1'b0;

    // in_valid while idle must not be consumed.
    in_valid = 1'b1;
    in_data  = 32'h4480_0000;
    step();
    checkOutput("idle ignores in_valid", 32'(busy), 32'd0);
    in_valid = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) samples[i] = vecs[v].d[i];
      applyStimulus(vecs[v].name, vecs[v].n, vecs[v].sub, 1'b0, 1, vecs[v].expected);
    end

    // len=0: result appears the cycle after start and nothing is consumed.
    start = 1'b1;
    len   = '0;
    step();
    start = 1'b0;
    checkOutput("len0 out_valid next cycle", 32'(out_valid), 32'd1);
    checkOutput("len0 no in_ready", 32'(in_ready), 32'd0);
    checkOutput("len0 out_data", out_data, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("len0 back to idle", 32'(busy), 32'd0);

    // len=4 with valid gaps, start pulses while busy and a 3-cycle stall.
    samples[0] = 32'h3F80_0000;
    samples[1] = 32'h4000_0000;
    samples[2] = 32'h4040_0000;
    samples[3] = 32'h4080_0000;
    applyStimulus("gaps4", 4, 1'b0, 1'b1, 3, 32'h4120_0000);

    // Reset after the second of four samples abandons the run.
    start = 1'b1;
    len   = CNT_W'(4);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    step();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst out_data", out_data, 32'h0);
    samples[0] = 32'h3F80_0000;
    applyStimulus("after_rst", 1, 1'b0, 1'b0, 0, 32'h3F80_0000);

    // Randomized jobs of small integers so every partial sum is exact.
    for (int j = 0; j < 25; j++) begin
      n   = $urandom_range(0, 10);
      sub = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) samples[i] = intToSingle(int'($urandom_range(0, 200)) - 100);
      applyStimulus($sformatf("rand%0d", j), n, sub, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), refModel(n, sub));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fp_accum_ctrl
